bram_be_dp: RTL and testbench

Parametrised dual-port block RAM model with per-byte write enables, configurable read latency, and read-during-write mode. Adds a built-in clear engine that zeroes the array after reset or on request, plus a sticky out-of-range flag. Serves the FIR lab as tap/data storage:
- Port A is the read/write side (AXI-Lite config / tap loader).
- Port B is read-only (FIR datapath).

---
 rtl/bram_pkg.sv | 28 ++
 rtl/bram_rd_pipe.sv | 47 ++++
 rtl/bram_be_dp.sv | 147 ++++++++++++++
 tb/tb_bram_be_dp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-enable dual-port block RAM.
package bram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (n > (32'd1 << i)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Byte address to word index; the byte-lane bits below lsb_w are dropped.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned lsb_w);
        return byte_addr >> lsb_w;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data latency pipeline: one or two EN-qualified output registers.
module bram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q
);

    logic [DATA_W-1:0] s1_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q <= '0;
        end else if (EN) begin
            s1_q <= D;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              en_d_q;
            logic [DATA_W-1:0] s2_q;

            // The second stage only advances when the first stage loaded a new word.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    en_d_q <= 1'b0;
                    s2_q   <= '0;
                end else begin
                    en_d_q <= EN;
                    if (en_d_q) begin
                        s2_q <= s1_q;
                    end
                end
            end

            assign Q = s2_q;
        end else begin : g_lat1
            assign Q = s1_q;
        end
    endgenerate

endmodule

// File: rtl/bram_be_dp.sv
// Dual-port block RAM with byte enables, clear sweep engine and sticky out-of-range flag.
// state | meaning
// CLEAR | sweep writes zero to word cnt each cycle, accesses blocked
// IDLE  | normal port A read/write and port B read access
module bram_be_dp
    import bram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 12,
    parameter int ADDR_W      = 12,
    parameter int RD_LAT      = 1,
    parameter int WRITE_FIRST = 0,
    parameter int CLR_ON_RST  = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     A_EN,
    input  logic [DATA_W/BYTE_W-1:0] A_WE,
    input  logic [ADDR_W-1:0]        A_A,
    input  logic [DATA_W-1:0]        A_Di,
    output logic [DATA_W-1:0]        A_Do,
    input  logic                     B_EN,
    input  logic [ADDR_W-1:0]        B_A,
    output logic [DATA_W-1:0]        B_Do,
    input  logic                     CLR,
    output logic                     READY,
    output logic                     ERR_OOR
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int LSB_W = clog2(NB);
    localparam int IDX_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       a_word, b_word;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic              a_in, b_in, a_wr, b_hit;
    logic [DATA_W-1:0] a_old, b_old, merged, a_rd, b_rd;

    assign a_word = word_index(32'(A_A), LSB_W);
    assign b_word = word_index(32'(B_A), LSB_W);
    assign a_in   = a_word < 32'(DEPTH);
    assign b_in   = b_word < 32'(DEPTH);
    assign a_idx  = a_word[IDX_W-1:0];
    assign b_idx  = b_word[IDX_W-1:0];
    assign a_old  = mem[a_idx];
    assign b_old  = mem[b_idx];

    assign READY  = (state_q == IDLE);
    assign a_wr   = A_EN && READY && a_in && (|A_WE);
    assign b_hit  = a_wr && (a_idx == b_idx);

    always_comb begin
        merged = a_old;
        for (int i = 0; i < NB; i++) begin
            if (A_WE[i]) begin
                merged[i*BYTE_W +: BYTE_W] = A_Di[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Same-word collisions forward the merged word only in write-first mode.
    always_comb begin
        a_rd = '0;
        b_rd = '0;
        if (READY && a_in) begin
            a_rd = ((WRITE_FIRST != 0) && a_wr) ? merged : a_old;
        end
        if (READY && b_in) begin
            b_rd = ((WRITE_FIRST != 0) && b_hit) ? merged : b_old;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if ((A_EN && !a_in) || (B_EN && !b_in)) begin
            err_d = 1'b1;
        end
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (CLR) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array contents deliberately survive RST_N; only the sweep zeroes them.
    always_ff @(posedge CLK) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (a_wr) begin
            mem[a_idx] <= merged;
        end
    end

    assign ERR_OOR = err_q;

    bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (A_EN),
        .D     (a_rd),
        .Q     (A_Do)
    );

    bram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (B_EN),
        .D     (b_rd),
        .Q     (B_Do)
    );

endmodule

// File: tb/tb_bram_be_dp.sv
// Bench for bram_be_dp: two instances (RD_LAT=1/read-first, RD_LAT=2/write-first) on shared stimulus.
module tb_bram_be_dp;

    localparam int DEPTH = 12;

    logic        CLK = 1'b0;
    logic        RST_N, A_EN, B_EN, CLR;
    logic [3:0]  A_WE;
    logic [11:0] A_A, B_A;
    logic [31:0] A_Di;
    logic [31:0] a_do0, b_do0, a_do1, b_do1;
    logic        rdy0, rdy1, err0, err1;

    always #5 CLK = ~CLK;

    bram_be_dp #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(12), .RD_LAT(1),
                 .WRITE_FIRST(0), .CLR_ON_RST(1)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .A_EN(A_EN), .A_WE(A_WE), .A_A(A_A),
        .A_Di(A_Di), .A_Do(a_do0), .B_EN(B_EN), .B_A(B_A), .B_Do(b_do0),
        .CLR(CLR), .READY(rdy0), .ERR_OOR(err0));

    bram_be_dp #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(12), .RD_LAT(2),
                 .WRITE_FIRST(1), .CLR_ON_RST(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .A_EN(A_EN), .A_WE(A_WE), .A_A(A_A),
        .A_Di(A_Di), .A_Do(a_do1), .B_EN(B_EN), .B_A(B_A), .B_Do(b_do1),
        .CLR(CLR), .READY(rdy1), .ERR_OOR(err1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a sweep is modelled as "array zero, blocked for DEPTH edges".
    logic [31:0] m_mem [DEPTH];
    bit          m_ready;
    int          m_left;
    bit          m_err;
    logic [31:0] e0a, e0b, s1a, s1b, e1a, e1b;
    bit          p_ena, p_enb;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ready = 0;
        m_left  = DEPTH;
        m_err   = 0;
        e0a = '0; e0b = '0; s1a = '0; s1b = '0; e1a = '0; e1b = '0;
        p_ena = 0; p_enb = 0;
    endtask

    task automatic model_edge();
        int          wa, wb;
        bit          a_in, b_in, wr;
        logic [31:0] old_a, old_b, nw, ra_old, ra_new, rb_old, rb_new;
        wa = int'(A_A >> 2);
        wb = int'(B_A >> 2);
        a_in = (wa < DEPTH);
        b_in = (wb < DEPTH);
        old_a = '0;
        old_b = '0;
        if (a_in) old_a = m_mem[wa];
        if (b_in) old_b = m_mem[wb];
        wr = A_EN && m_ready && a_in && (A_WE != 4'h0);
        nw = old_a;
        for (int i = 0; i < 4; i++) if (A_WE[i]) nw[8*i +: 8] = A_Di[8*i +: 8];
        ra_old = '0; ra_new = '0; rb_old = '0; rb_new = '0;
        if (m_ready && a_in) begin
            ra_old = old_a;
            ra_new = wr ? nw : old_a;
        end
        if (m_ready && b_in) begin
            rb_old = old_b;
            rb_new = (wr && wa == wb) ? nw : old_b;
        end
        if (p_ena) e1a = s1a;
        if (p_enb) e1b = s1b;
        if (A_EN) begin e0a = ra_old; s1a = ra_new; end
        if (B_EN) begin e0b = rb_old; s1b = rb_new; end
        p_ena = A_EN;
        p_enb = B_EN;
        if ((A_EN && !a_in) || (B_EN && !b_in)) m_err = 1;
        if (wr) m_mem[wa] = nw;
        if (m_ready) begin
            if (CLR) begin
                m_err   = 0;
                m_ready = 0;
                m_left  = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_ready = 1;
        end
    endtask

    task automatic compare_all();
        check("ready0", {31'b0, rdy0}, {31'b0, m_ready});
        check("ready1", {31'b0, rdy1}, {31'b0, m_ready});
        check("err0",   {31'b0, err0}, {31'b0, m_err});
        check("err1",   {31'b0, err1}, {31'b0, m_err});
        check("a_do0",  a_do0, e0a);
        check("b_do0",  b_do0, e0b);
        check("a_do1",  a_do1, e1a);
        check("b_do1",  b_do1, e1b);
    endtask

    task automatic set_in(input bit aen, input logic [3:0] we, input logic [11:0] aa,
                          input logic [31:0] di, input bit ben, input logic [11:0] ba,
                          input bit clr);
        A_EN = aen; A_WE = we; A_A = aa; A_Di = di; B_EN = ben; B_A = ba; CLR = clr;
    endtask

    task automatic idle_in();
        set_in(0, 4'h0, 12'h0, 32'h0, 0, 12'h0, 0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_a_do0", a_do0, 32'h0);
        check("rst_b_do1", b_do1, 32'h0);
        check("rst_err0",  {31'b0, err0}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        idle_in();
        model_reset();
        @(negedge CLK);
        compare_all();
        RST_N = 1'b1;

        // Reset sweep: READY low for DEPTH edges, then all words read zero.
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check("sweep_ready_low", {31'b0, rdy0}, 32'h0);
        tick();
        check("sweep_ready_high", {31'b0, rdy0}, 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 4'h0, 12'h0, 32'h0, 1, 12'(i * 4), 0);
            tick();
            check("sweep_zero", b_do0, 32'h0);
        end
        idle_in();
        tick();

        // Byte-enable merge.
        set_in(1, 4'hF, 12'h008, 32'hAABBCCDD, 0, 12'h0, 0); tick();
        set_in(1, 4'h2, 12'h008, 32'h11223344, 0, 12'h0, 0); tick();
        set_in(1, 4'h0, 12'h00A, 32'h0, 0, 12'h0, 0);        tick();
        check("be_lat1", a_do0, 32'hAABB33DD);
        idle_in(); tick();
        check("be_lat2", a_do1, 32'hAABB33DD);

        // Collision: A writes word 3 while B reads it.
        set_in(1, 4'hF, 12'h00C, 32'h5, 0, 12'h0, 0); tick();
        set_in(1, 4'hF, 12'h00C, 32'h9, 1, 12'h00C, 0); tick();
        check("coll_read_first", b_do0, 32'h5);
        idle_in(); tick();
        check("coll_write_first", b_do1, 32'h9);

        // Out of range write to word 12.
        set_in(1, 4'hF, 12'h030, 32'hDEADBEEF, 0, 12'h0, 0); tick();
        check("oor_err", {31'b0, err0}, 32'h1);
        check("oor_ado", a_do0, 32'h0);
        idle_in();
        for (int i = 0; i < 3; i++) tick();
        check("oor_sticky", {31'b0, err1}, 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 4'h0, 12'h0, 32'h0, 1, 12'(i * 4), 0);
            tick();
        end
        idle_in(); tick();

        // CLR with data present; write and CLR during sweep are ignored.
        set_in(0, 4'h0, 12'h0, 32'h0, 0, 12'h0, 1); tick();
        check("clr_err", {31'b0, err0}, 32'h0);
        set_in(1, 4'hF, 12'h008, 32'hFFFFFFFF, 0, 12'h0, 0); tick();
        set_in(0, 4'h0, 12'h0, 32'h0, 0, 12'h0, 1); tick();
        idle_in();
        for (int i = 0; i < DEPTH - 3; i++) tick();
        check("clr_ready_low", {31'b0, rdy1}, 32'h0);
        tick();
        check("clr_ready_high", {31'b0, rdy1}, 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 4'h0, 12'(i * 4), 32'h0, 1, 12'(i * 4), 0);
            tick();
            check("clr_zero", a_do0, 32'h0);
        end
        idle_in(); tick();

        // Reset with live outputs and ERR_OOR set, then reset again mid-sweep.
        set_in(1, 4'hF, 12'h004, 32'h12345678, 0, 12'h0, 0); tick();
        set_in(1, 4'h0, 12'h004, 32'h0, 1, 12'h004, 0); tick();
        set_in(0, 4'h0, 12'h0, 32'h0, 1, 12'h03C, 0); tick();
        idle_in(); tick();
        check("pre_rst_ado", a_do0, 32'h12345678);
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check("rst2_ready_low", {31'b0, rdy0}, 32'h0);
        tick();
        check("rst2_ready_high", {31'b0, rdy0}, 32'h1);

        // Randomized traffic including out-of-range words and occasional CLR.
        for (int n = 0; n < 600; n++) begin
            set_in(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   12'($urandom_range(0, 63)), $urandom,
                   bit'($urandom_range(0, 1)), 12'($urandom_range(0, 63)),
                   ($urandom_range(0, 39) == 0));
            tick();
        end
        idle_in();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
